// File: rtl/snoop_pkg.sv
// Snoop agent types and the shared snoop decision function.
// SNOOP_RESP_DVM_EN: answer DVM snoops with resp 0; otherwise they are flagged as errors.
package snoop_pkg;

  typedef enum logic [3:0] {
    SNP_READ_ONCE     = 4'b0000,
    SNP_READ_SHARED   = 4'b0001,
    SNP_READ_CLEAN    = 4'b0010,
    SNP_READ_NSD      = 4'b0011,
    SNP_READ_UNIQUE   = 4'b0111,
    SNP_CLEAN_SHARED  = 4'b1000,
    SNP_CLEAN_INVALID = 4'b1001,
    SNP_MAKE_INVALID  = 4'b1101,
    SNP_DVM_COMPLETE  = 4'b1110,
    SNP_DVM_MESSAGE   = 4'b1111
  } acsnoop_t;

  typedef logic [2:0] acprot_t;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic hit;
    logic dirty;
    logic shared;
  } line_state_t;

  typedef struct packed {
    logic invalidate;
    logic clean;
    logic shared;
  } snoop_upd_t;

  typedef struct packed {
    crresp_t    resp;
    snoop_upd_t upd;
  } snoop_dec_t;

  function automatic logic snoop_needs_lookup(acsnoop_t snp);
    case (snp)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN,
      SNP_READ_NSD, SNP_READ_UNIQUE, SNP_CLEAN_SHARED,
      SNP_CLEAN_INVALID, SNP_MAKE_INVALID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic snoop_dec_t snoop_decide(
    acsnoop_t    snp,
    line_state_t ls
  );
    snoop_dec_t d;
    d = '0;
    case (snp)
      SNP_READ_ONCE: begin
        d.resp.is_shared     = 1'b1;
        d.resp.data_transfer = 1'b1;
      end
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
        d.resp.is_shared     = 1'b1;
        d.resp.data_transfer = 1'b1;
        d.resp.pass_dirty    = ls.dirty;
        d.upd.shared         = 1'b1;
        d.upd.clean          = ls.dirty;
      end
      SNP_READ_UNIQUE: begin
        d.resp.data_transfer = 1'b1;
        d.resp.pass_dirty    = ls.dirty;
        d.upd.invalidate     = 1'b1;
      end
      SNP_CLEAN_SHARED: begin
        d.resp.data_transfer = ls.dirty;
        d.resp.pass_dirty    = ls.dirty;
        d.resp.is_shared     = 1'b1;
        d.upd.clean          = ls.dirty;
      end
      SNP_CLEAN_INVALID: begin
        d.resp.data_transfer = ls.dirty;
        d.resp.pass_dirty    = ls.dirty;
        d.upd.invalidate     = 1'b1;
      end
      SNP_MAKE_INVALID: begin
        d.upd.invalidate = 1'b1;
      end
`ifdef SNOOP_RESP_DVM_EN
      SNP_DVM_COMPLETE, SNP_DVM_MESSAGE: begin
        return d;
      end
`endif
      default: begin
        d.resp.error = 1'b1;
        return d;
      end
    endcase
    d.resp.was_unique = !ls.shared;
    // A miss answers with an all-zero response and leaves the line alone
    if (!ls.hit) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/snoop_cache_responder.sv
// Snoop-side responder: AC request -> tag lookup -> CR response -> CD beats -> state update.
// SNOOP_RESP_DVM_EN (see snoop_pkg) selects DVM support.
module snoop_cache_responder
  import snoop_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int CdBeats   = 4,
  localparam int IdxW     = (CdBeats > 1) ? $clog2(CdBeats) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lu_req_o,
  output logic [AddrWidth-1:0] lu_addr_o,
  input  logic                 lu_hit_i,
  input  logic                 lu_dirty_i,
  input  logic                 lu_shared_i,
  output logic                 rd_req_o,
  output logic [IdxW-1:0]      rd_idx_o,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic                 upd_valid_o,
  output logic                 upd_invalidate_o,
  output logic                 upd_clean_o,
  output logic                 upd_shared_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESP, S_RD, S_SEND
  } state_e;

  state_e              state_q, state_d;
  acsnoop_t            snoop_q;
  logic                look_q;
  crresp_t             resp_q;
  snoop_upd_t          upd_q;
  logic [IdxW-1:0]     cnt_q;
  logic [DataWidth-1:0] data_q;
  logic                cap_q;

  acsnoop_t    ac_snoop;
  line_state_t ls;
  snoop_dec_t  dec;
  logic        ac_hs, cd_hs, last_beat, upd_fire;
  logic        unused_prot;

  assign unused_prot = ^ac_prot_i;
  assign ac_snoop    = acsnoop_t'(ac_snoop_i);
  assign ac_hs       = (state_q == S_IDLE) && ac_valid_i;
  assign cd_hs       = (state_q == S_SEND) && cd_ready_i;
  assign last_beat   = cnt_q == IdxW'(CdBeats - 1);
  assign ls          = '{hit: lu_hit_i & look_q,
                         dirty: lu_dirty_i,
                         shared: lu_shared_i};
  assign dec         = snoop_decide(snoop_q, ls);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snoop_q <= SNP_READ_ONCE;
      look_q  <= 1'b0;
      resp_q  <= '0;
      upd_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      cap_q   <= 1'b0;
    end else begin
      if (ac_hs) begin
        snoop_q <= ac_snoop;
        look_q  <= snoop_needs_lookup(ac_snoop);
      end
      if (state_q == S_LOOKUP) begin
        resp_q <= dec.resp;
        upd_q  <= dec.upd;
      end
      // First SEND cycle forwards the array output, later cycles replay it
      if (state_q == S_SEND && !cap_q) data_q <= rd_data_i;
      cap_q <= (state_q == S_SEND) && !cd_hs;
      if (cd_hs) cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (ac_valid_i) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_RESP;
      S_RESP:
        if (cr_ready_i)
          state_d = resp_q.data_transfer ? S_RD : S_IDLE;
      S_RD:     state_d = S_SEND;
      S_SEND:
        if (cd_ready_i)
          state_d = last_beat ? S_IDLE : S_RD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ac_ready_o = 1'b0;
    lu_req_o   = 1'b0;
    lu_addr_o  = '0;
    cr_valid_o = 1'b0;
    cr_resp_o  = '0;
    rd_req_o   = 1'b0;
    rd_idx_o   = '0;
    cd_valid_o = 1'b0;
    cd_data_o  = '0;
    cd_last_o  = 1'b0;
    upd_fire   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ac_ready_o = 1'b1;
        lu_req_o   = ac_valid_i & snoop_needs_lookup(ac_snoop);
        lu_addr_o  = lu_req_o ? ac_addr_i : '0;
      end
      S_RESP: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = resp_q;
        upd_fire   = cr_ready_i & !resp_q.data_transfer;
      end
      S_RD: begin
        rd_req_o = 1'b1;
        rd_idx_o = cnt_q;
      end
      S_SEND: begin
        cd_valid_o = 1'b1;
        cd_data_o  = cap_q ? data_q : rd_data_i;
        cd_last_o  = last_beat;
        upd_fire   = cd_ready_i & last_beat;
      end
      default: ;
    endcase
    upd_valid_o      = upd_fire & (|upd_q);
    upd_invalidate_o = upd_valid_o & upd_q.invalidate;
    upd_clean_o      = upd_valid_o & upd_q.clean;
    upd_shared_o     = upd_valid_o & upd_q.shared;
  end

endmodule

// File: tb/tb_snoop_cache_responder.sv
// Scoreboard bench for snoop_cache_responder.
// Expected CR/CD/update items are queued at issue and retired by a monitor.
module tb_snoop_cache_responder;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NB = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ac_valid = 1'b0;
  logic          ac_ready;
  logic [AW-1:0] ac_addr = '0;
  logic [3:0]    ac_snoop = '0;
  logic          cr_valid, cr_ready = 1'b1;
  logic [4:0]    cr_resp;
  logic          cd_valid, cd_ready = 1'b1;
  logic [DW-1:0] cd_data;
  logic          cd_last;
  logic          lu_req;
  logic [AW-1:0] lu_addr;
  logic          lu_hit = 1'b0, lu_dirty = 1'b0, lu_shared = 1'b0;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data = '0;
  logic          upd_valid, upd_inv, upd_clean, upd_shared;

  snoop_cache_responder #(
    .AddrWidth(AW), .DataWidth(DW), .CdBeats(NB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid), .ac_ready_o(ac_ready),
    .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
    .ac_prot_i(3'b010),
    .cr_valid_o(cr_valid), .cr_ready_i(cr_ready),
    .cr_resp_o(cr_resp),
    .cd_valid_o(cd_valid), .cd_ready_i(cd_ready),
    .cd_data_o(cd_data), .cd_last_o(cd_last),
    .lu_req_o(lu_req), .lu_addr_o(lu_addr),
    .lu_hit_i(lu_hit), .lu_dirty_i(lu_dirty),
    .lu_shared_i(lu_shared),
    .rd_req_o(rd_req), .rd_idx_o(rd_idx),
    .rd_data_i(rd_data),
    .upd_valid_o(upd_valid),
    .upd_invalidate_o(upd_inv),
    .upd_clean_o(upd_clean),
    .upd_shared_o(upd_shared)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask

  logic [4:0]  crq[$];
  logic [64:0] cdq[$];
  logic [2:0]  updq[$];
  int          lu_cnt, cd_cnt, upd_seen;
  int          cur_tag = 0;
  logic [AW-1:0] cur_addr = '0;
  bit          bp_mode = 0;
  int          cr_hold = 0;

  function automatic logic [DW-1:0] mk(int tag, int idx);
    return 64'hC0DE_0000_0000_0000 | (64'(tag) << 8) | 64'(idx);
  endfunction

  // Data array: answers the cycle after a read strobe, holds until the next
  initial begin
    logic pend;
    logic [IW-1:0] pidx;
    forever begin
      @(negedge clk);
      pend = rd_req;
      pidx = rd_idx;
      @(posedge clk);
      #1;
      if (pend) rd_data = mk(cur_tag, int'(pidx));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        if (cr_valid && cr_hold < 5) begin
          cr_ready = 1'b0;
          cr_hold++;
        end else begin
          cr_ready = 1'b1;
        end
        cd_ready = ~cd_ready;
      end else begin
        cr_ready = 1'b1;
        cd_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      if (lu_req) begin
        lu_cnt++;
        chk("lu_addr", lu_addr, cur_addr);
      end
      if (cr_valid) begin
        chk("ac_busy_cr", 64'(ac_ready), 64'd0);
        if (crq.size() == 0) chk("cr_unexp", 64'd1, 64'd0);
        else begin
          chk("cr_resp", 64'(cr_resp), 64'(crq[0]));
          if (cr_ready) void'(crq.pop_front());
        end
      end
      if (cd_valid) begin
        chk("ac_busy_cd", 64'(ac_ready), 64'd0);
        chk("cr_before_cd", 64'(crq.size()), 64'd0);
        if (cdq.size() == 0) chk("cd_unexp", 64'd1, 64'd0);
        else begin
          chk("cd_data", cd_data, cdq[0][63:0]);
          chk("cd_last", 64'(cd_last), 64'(cdq[0][64]));
          if (cd_ready) begin
            void'(cdq.pop_front());
            cd_cnt++;
          end
        end
      end
      if (upd_valid) begin
        upd_seen++;
        if (updq.size() == 0) chk("upd_unexp", 64'd1, 64'd0);
        else chk("upd_flags", 64'({upd_inv, upd_clean, upd_shared}),
                 64'(updq.pop_front()));
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"},
        64'({ac_ready, cr_valid, cd_valid, cd_last, lu_req, rd_req,
             upd_valid, upd_inv, upd_clean, upd_shared}),
        64'b10_0000_0000);
    chk({tag, "_resp"}, 64'(cr_resp), 64'd0);
    chk({tag, "_data"}, cd_data, 64'd0);
    chk({tag, "_addr"}, lu_addr, 64'd0);
    chk({tag, "_idx"}, 64'(rd_idx), 64'd0);
  endtask

  task automatic issue(input logic [3:0] snp,
                       input logic hit, input logic dirty,
                       input logic shared, input logic [4:0] er,
                       input int beats, input bit has_upd,
                       input logic [2:0] eu, input int elu);
    bit got;
    cur_tag++;
    cur_addr = 64'h0000_8000_0000_0000 + 64'(cur_tag) * 64;
    lu_hit = hit;
    lu_dirty = dirty;
    lu_shared = shared;
    lu_cnt = 0;
    cd_cnt = 0;
    crq.push_back(er);
    for (int b = 0; b < beats; b++)
      cdq.push_back({b == beats - 1, mk(cur_tag, b)});
    if (has_upd) updq.push_back(eu);
    @(posedge clk);
    #1;
    ac_valid = 1'b1;
    ac_addr = cur_addr;
    ac_snoop = snp;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ac_ready) begin
        got = 1;
        break;
      end
    end
    chk("ac_accept", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    ac_valid = 1'b0;
    ac_addr = '0;
  endtask

  task automatic finish_snoop(input int beats, input int elu);
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ac_ready) begin
        done = 1;
        break;
      end
    end
    chk("complete", 64'(done), 64'd1);
    chk("lu_count", 64'(lu_cnt), 64'(elu));
    chk("cd_beats", 64'(cd_cnt), 64'(beats));
    chk("q_empty", 64'(crq.size() + cdq.size() + updq.size()), 64'd0);
  endtask

  task automatic snoop(input logic [3:0] snp,
                       input logic hit, input logic dirty,
                       input logic shared, input logic [4:0] er,
                       input int beats, input bit has_upd,
                       input logic [2:0] eu, input int elu);
    issue(snp, hit, dirty, shared, er, beats, has_upd, eu, elu);
    finish_snoop(beats, elu);
  endtask

  initial begin
    bit hit_b2;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("ac_ready_post_reset", 64'(ac_ready), 64'd1);

    // snp, hit, dirty, shared, resp, beats, upd?, {inv,clean,shared}, lookups
    snoop(4'b0111, 1, 1, 0, 5'b10101, NB, 1, 3'b100, 1);
    snoop(4'b0001, 1, 0, 1, 5'b01001, NB, 1, 3'b001, 1);
    snoop(4'b1000, 1, 0, 0, 5'b11000, 0,  0, 3'b000, 1);
    snoop(4'b1000, 0, 0, 0, 5'b00000, 0,  0, 3'b000, 1);
    snoop(4'b0100, 1, 1, 0, 5'b00010, 0,  0, 3'b000, 0);
    snoop(4'b1001, 1, 1, 1, 5'b00101, NB, 1, 3'b100, 1);
    snoop(4'b0000, 1, 1, 0, 5'b11001, NB, 0, 3'b000, 1);
    snoop(4'b1101, 1, 0, 0, 5'b10000, 0,  1, 3'b100, 1);
    snoop(4'b0111, 0, 1, 0, 5'b00000, 0,  0, 3'b000, 1);
`ifdef SNOOP_RESP_DVM_EN
    snoop(4'b1111, 1, 1, 0, 5'b00000, 0,  0, 3'b000, 0);
`else
    snoop(4'b1111, 1, 1, 0, 5'b00010, 0,  0, 3'b000, 0);
`endif

    cr_hold = 0;
    bp_mode = 1;
    snoop(4'b0011, 1, 1, 0, 5'b11101, NB, 1, 3'b011, 1);
    bp_mode = 0;
    chk("bp_cr_stall", 64'(cr_hold), 64'd5);

    issue(4'b0010, 1, 0, 0, 5'b11001, NB, 1, 3'b001, 1);
    hit_b2 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cd_valid && cd_cnt == 1) begin
        hit_b2 = 1;
        break;
      end
    end
    chk("reach_beat2", 64'(hit_b2), 64'd1);
    #2 rst_ni = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    crq.delete();
    cdq.delete();
    updq.delete();
    upd_seen = 0;
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 64'(ac_ready), 64'd1);
    chk("post_rst_no_upd", 64'(upd_seen), 64'd0);
    chk("post_rst_no_cr", 64'(cr_valid), 64'd0);

    snoop(4'b0111, 1, 0, 0, 5'b10001, NB, 1, 3'b100, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
